// File: rtl/bus_arbiter_mux.sv
// Registered common-bus mux: an internal round-robin/fixed-priority arbiter picks one of CHANNELS sources into a one-word output stage.
// Latency: grant is combinational, OUT is valid from the next edge; with ready low the stage holds its word and issues no grant.
module bus_arbiter_mux #(
   parameter int WORD     = 16,
   parameter int CHANNELS = 8,
   parameter int SEL_W    = $clog2(CHANNELS)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [CHANNELS-1:0]      req,
   input  logic [CHANNELS*WORD-1:0] IN_BUS,
   input  logic                     mode,
   input  logic                     ready,
   output logic [CHANNELS-1:0]      grant,
   output logic [WORD-1:0]          OUT,
   output logic                     out_valid,
   output logic [SEL_W-1:0]         select_out
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t           st_q;
   state_t           st_d;
   logic [SEL_W-1:0] ptr;
   logic [SEL_W-1:0] rr_win;
   logic [SEL_W-1:0] fp_win;
   logic [SEL_W-1:0] win;
   logic [SEL_W:0]   rr_idx;
   logic             rr_found;
   logic             load;
   logic             grant_en;

   // Round-robin: walk ptr, ptr+1, ... with wrap; one extra bit keeps the sum from overflowing.
   always_comb begin
      rr_win   = '0;
      rr_idx   = '0;
      rr_found = 1'b0;
      for (int k = 0; k < CHANNELS; k++) begin
         rr_idx = {1'b0, ptr} + (SEL_W+1)'(k);
         if (rr_idx >= (SEL_W+1)'(CHANNELS)) begin
            rr_idx = rr_idx - (SEL_W+1)'(CHANNELS);
         end
         if (!rr_found && req[rr_idx[SEL_W-1:0]]) begin
            rr_win   = rr_idx[SEL_W-1:0];
            rr_found = 1'b1;
         end
      end
   end

   always_comb begin
      fp_win = '0;
      for (int k = CHANNELS - 1; k >= 0; k--) begin
         if (req[k]) begin
            fp_win = SEL_W'(k);
         end
      end
   end

   assign win      = mode ? fp_win : rr_win;
   assign load     = (|req) && (!out_valid || ready);
   assign grant_en = load && !rst;
   assign grant    = grant_en ? (CHANNELS'(1) << win) : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st_q <= EMPTY;
      end else begin
         st_q <= st_d;
      end
   end

   always_comb begin
      st_d = st_q;
      case (st_q)
         EMPTY: if (load) st_d = FULL;
         FULL:  if (ready && !(|req)) st_d = EMPTY;
         default: st_d = EMPTY;
      endcase
   end

   always_comb begin
      out_valid = (st_q == FULL);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         OUT        <= '0;
         select_out <= '0;
      end else if (load) begin
         OUT        <= IN_BUS[win*WORD +: WORD];
         select_out <= win;
      end
   end

   // Fixed-priority loads leave the rotation point alone so round-robin resumes where it left off.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr <= '0;
      end else if (load && !mode) begin
         ptr <= (win == SEL_W'(CHANNELS - 1)) ? '0 : win + SEL_W'(1);
      end
   end

endmodule

// File: doc/bus_arbiter_mux.md
# bus_arbiter_mux

Parametrised successor to the Basic Computer common-bus multiplexer: selects one of CHANNELS word-wide sources onto a registered output. Selection comes from an internal arbiter, round-robin or fixed-priority, instead of an externally driven select code. The output stage holds one word with a valid/ready handshake, so bus transfers can be back-pressured without losing data. It sits between register/memory sources and any consumer of the common bus.

## Interface
- WORD, 16, data width in bits
- CHANNELS, 8, number of sources; legal range 2..16
- SEL_W, $clog2(CHANNELS), width of the encoded channel index
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-high
- req  input  CHANNELS  per-channel request; bit i means IN_BUS slice i holds a word to transfer
- IN_BUS  input  CHANNELS*WORD  flattened sources; channel i is IN_BUS[i*WORD +: WORD]
- mode  input  1  0 = round-robin, 1 = fixed priority (lowest index wins)
- ready  input  1  downstream accepts OUT this cycle
- grant  output  CHANNELS  one-hot, combinational; high in the cycle channel i's word is captured
- OUT  output  WORD  registered output word
- out_valid  output  1  OUT holds an unconsumed word
- select_out  output  SEL_W  index of the channel whose word is in OUT

## Operation
- Output register states: EMPTY (out_valid=0) and FULL (out_valid=1).
- Load enable: `load = (|req) && (!out_valid || ready)`.
- When load=1:
  - Arbiter picks winner w.
  - grant[w]=1 combinationally; all other grant bits are 0.
  - At the clock edge: OUT <= channel w, select_out <= w, out_valid <= 1.
- When load=0, grant = 0.
- If FULL && ready && no req: out_valid <= 0; OUT and select_out hold their last values.
- If FULL && !ready: OUT, select_out and out_valid hold; grant = 0 regardless of req.
- Round-robin (mode=0):
  - Search order is ptr, ptr+1, …, CHANNELS-1, 0, …, ptr-1; first set req bit wins.
  - On every load, ptr <= (w+1) mod CHANNELS.
- Fixed priority (mode=1):
  - Lowest set req index wins.
  - ptr does not change.
- mode is sampled combinationally each cycle, so a change takes effect at the next load decision.
- A requester treats grant[i] as consumption of its current word. It deasserts req[i] or presents the next word on the following cycle.
- Words are never dropped or duplicated. Exactly one capture happens per grant pulse.
- req bits for non-existent channels cannot occur, because req is exactly CHANNELS wide.
- Reset values (asynchronous, immediate on rst=1): OUT=0, out_valid=0, select_out=0, ptr=0. grant is 0 while rst=1.
- Reset mid-transfer discards the held word. No grant is issued in any cycle where rst=1.

## Timing
- Latency: capture at edge N (grant high in cycle N-1) makes OUT/out_valid valid from edge N.
- Throughput: one word per cycle when ready is held high and req is nonzero.
- Simultaneous consume and capture (FULL, ready=1, req≠0):
  - The old word is consumed and the new word loaded at the same edge.
  - out_valid stays 1 with no bubble.
- grant and the arbiter decision are combinational from req, ptr, mode, out_valid and ready. There is no combinational path from IN_BUS to any output.
- ptr wrap: when w = CHANNELS-1, ptr becomes 0.

## Test plan
- Reset: drive rst=1 with req=8'hFF → OUT=0, out_valid=0, select_out=0, grant=0. After release, the first load grants channel 0.
- Single source: req=8'b0000_0100, IN_2=16'hA5A5, ready=1:
  - grant=8'b0000_0100 in the same cycle.
  - Next cycle OUT=16'hA5A5, select_out=2, out_valid=1.
- Round-robin fairness: req=8'hFF, mode=0, ready=1 for 10 cycles:
  - select_out sequence is 0,1,…,7,0,1.
  - grant one-hot every cycle.
- Fixed priority: req=8'b1001_0010, mode=1 for 3 cycles → select_out=1 every load, ptr unchanged. Switching to mode=0 with ptr=0 gives order 1,4,7.
- Back-pressure: FULL with OUT=16'h1234, ready=0 for 5 cycles while req=8'hFF:
  - grant=0 and OUT=16'h1234 hold throughout.
  - On ready=1, OUT is replaced in the same edge, with no bubble.
- Reset mid-operation: assert rst while FULL and ready=0 → out_valid=0 and OUT=0 immediately, without waiting for a clock edge. After release, arbitration restarts from channel 0.
